// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one Booth multiplier (control unit plus datapath) between NREQ
//   clients. A round-robin arbiter picks a requester, latches its operands,
//   pulses the multiplier start, waits for fin, captures the product and
//   hands it back with a one-cycle done pulse.
//
// Parameters
//   NREQ     number of requesters (2..4)
//   W        operand width; products are 2W bits, two's complement
//   TIMEOUT  WAIT-cycle limit, only meaningful with BOOTH_ARB_TIMEOUT_EN
//
// Optional feature macro: BOOTH_ARB_TIMEOUT_EN
//   When defined, a job whose fin never arrives is aborted after TIMEOUT
//   WAIT cycles with result=0 and a one-cycle err alongside done.
//   When undefined, WAIT holds until fin and err is tied low.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-requester request level
//   op_m       flattened multiplicands, slice i = [i*W +: W]
//   op_q       flattened multipliers, same slicing
//   gnt        one-hot grant, held from grant through DONE
//   done       one-cycle completion pulse to the granted requester
//   result     last captured product, held until the next capture
//   err        one-cycle timeout pulse (0 unless the feature is built in)
//   mul_start  start pulse to the multiplier control unit
//   mul_m      latched multiplicand to the datapath
//   mul_q      latched multiplier to the datapath
//   mul_fin    fin from the multiplier control unit
//   mul_prod   product from the datapath

module booth_mult_arbiter #(
  parameter int NREQ    = 2,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_m,
  input  logic [NREQ*W-1:0] op_q,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    result,
  output logic              err,
  output logic              mul_start,
  output logic [W-1:0]      mul_m,
  output logic [W-1:0]      mul_q,
  input  logic              mul_fin,
  input  logic [2*W-1:0]    mul_prod
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST    = IW'(NREQ - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   winner;
  logic [CW-1:0]   wait_cnt;

  logic [IW-1:0]   pick;
  logic [NREQ-1:0] pick_oh;
  logic [W-1:0]    sel_m;
  logic [W-1:0]    sel_q;

  // Round-robin pick: the lowest requester at or above ptr wins; if none is
  // at or above ptr, the search wraps and the lowest requester overall wins.
  // The second loop overrides the first only when a candidate >= ptr exists.
  always_comb begin
    pick = ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) pick = IW'(i);
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) >= ptr)) pick = IW'(i);
    end
  end

  // Operand mux and one-hot decode for the current pick.
  always_comb begin
    sel_m   = '0;
    sel_q   = '0;
    pick_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      pick_oh[i] = (IW'(i) == pick);
      if (IW'(i) == pick) begin
        sel_m = op_m[i*W +: W];
        sel_q = op_q[i*W +: W];
      end
    end
  end

  // Control FSM with registered outputs. gnt already holds the winner's
  // one-hot, so done is simply a copy of gnt on the edge into DONE.
  // wait_cnt saturates so a very long job never wraps back to zero, which
  // would otherwise re-arm the first-cycle fin mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      winner    <= '0;
      wait_cnt  <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      mul_start <= 1'b0;
      mul_m     <= '0;
      mul_q     <= '0;
      result    <= '0;
    end else begin
      mul_start <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            winner    <= pick;
            gnt       <= pick_oh;
            mul_m     <= sel_m;
            mul_q     <= sel_q;
            mul_start <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt != CNT_MAX) wait_cnt <= wait_cnt + 1'b1;
          // A fin seen in the first WAIT cycle belongs to the previous job.
          if (mul_fin && (wait_cnt != '0)) begin
            result <= mul_prod;
            done   <= gnt;
            state  <= DONE;
          end
`ifdef BOOTH_ARB_TIMEOUT_EN
          else if (wait_cnt == CNT_LIMIT) begin
            result <= '0;
            err    <= 1'b1;
            done   <= gnt;
            state  <= DONE;
          end
`endif
        end
        DONE: begin
          ptr   <= (winner == LAST) ? '0 : winner + 1'b1;
          gnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
